// File: rtl/user_input_pkg.sv
// Shared definitions for the user-input interrupt controller: register map,
// input counts and the bit positions of keys and switches in every register.
package user_input_pkg;

    localparam int NUM_KEYS   = 4;
    localparam int NUM_SW     = 4;
    localparam int NUM_INPUTS = NUM_KEYS + NUM_SW;

    // Keys occupy the low nibble, switches the next one up.
    localparam int KEY_OFFSET = 0;
    localparam int SW_OFFSET  = KEY_OFFSET + NUM_KEYS;

    typedef enum logic [1:0] {
        ADDR_STATUS  = 2'd0,
        ADDR_PENDING = 2'd1,
        ADDR_MASK    = 2'd2,
        ADDR_CAPTURE = 2'd3
    } regAddr_t;

    // Places an input-wide register value on the 32-bit bus, upper bits zero.
    function automatic logic [31:0] zeroExtend(input logic [NUM_INPUTS-1:0] value);
        return {{(32-NUM_INPUTS){1'b0}}, value};
    endfunction

endpackage

// File: rtl/user_input_irq_ctrl_debounce.sv
// One-bit input conditioner: 2-FF synchroniser followed by a saturating
// stability counter. o_update flags the cycle on which o_level will flip.
module input_debounce #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_update
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic [CNT_W-1:0] r_count;
    logic             w_differs;
    logic             w_expired;

    assign w_differs = (r_sync1 != r_level);
    assign w_expired = (r_count == CNT_MAX);
    assign o_level   = r_level;
    assign o_update  = w_differs && w_expired;

    // Synchronise the pin, count consecutive disagreeing cycles, adopt the new level once the count is full.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync0 <= RESET_VALUE;
            r_sync1 <= RESET_VALUE;
            r_level <= RESET_VALUE;
            r_count <= '0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
            if (!w_differs) begin
                r_count <= '0;
            end else if (w_expired) begin
                r_level <= r_sync1;
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/user_input_irq_ctrl.sv
// Interrupt controller for the board push-buttons and slide switches.
// Debounced key presses and switch changes latch into PENDING; the HPS
// reads and clears them over Avalon-MM and sees a level interrupt.
module user_input_irq_ctrl
    import user_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  keys,
    input  logic [3:0]  switches,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int               ARM_W   = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(DEBOUNCE_CYCLES + 2);

    logic [NUM_INPUTS-1:0] w_raw;
    logic [NUM_INPUTS-1:0] w_level;
    logic [NUM_INPUTS-1:0] w_update;
    logic [NUM_INPUTS-1:0] w_event;
    logic [NUM_INPUTS-1:0] w_status;
    logic [NUM_INPUTS-1:0] w_clearBits;
    logic                  w_unusedBits;

    logic [ARM_W-1:0]      r_armCount;
    logic                  r_armed;
    logic [NUM_INPUTS-1:0] r_event;
    logic [NUM_INPUTS-1:0] r_pending;
    logic [NUM_INPUTS-1:0] r_mask;
    logic [NUM_INPUTS-1:0] r_capture;

    assign w_raw        = {switches, keys};
    assign w_unusedBits = ^avs_writedata[31:NUM_INPUTS];
    assign w_clearBits  = (avs_write && (avs_address == ADDR_PENDING))
                          ? avs_writedata[NUM_INPUTS-1:0] : '0;

    // Keys idle high (released), switches idle low.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_input
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    ((i < SW_OFFSET) ? 1'b1 : 1'b0)
        ) u_debounce (
            .i_clk   (clk),
            .i_reset (reset),
            .i_raw   (w_raw[i]),
            .o_level (w_level[i]),
            .o_update(w_update[i])
        );
    end

    // Events come from the debouncer's flip strobe; keys count only the press (current level 1 about to go 0).
    always_comb begin
        w_event = w_update;
        w_event[KEY_OFFSET +: NUM_KEYS] = w_update[KEY_OFFSET +: NUM_KEYS] & w_level[KEY_OFFSET +: NUM_KEYS];
    end

    // Status view inverts the active-low keys so that 1 always means pressed.
    always_comb begin
        w_status = w_level;
        w_status[KEY_OFFSET +: NUM_KEYS] = ~w_level[KEY_OFFSET +: NUM_KEYS];
    end

    // Arming: the armed flag trails the counter by one cycle so that the first settle flip after reset is also swallowed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armCount <= '0;
            r_armed    <= 1'b0;
        end else begin
            if (r_armCount != ARM_MAX) begin
                r_armCount <= r_armCount + ARM_W'(1);
            end
            r_armed <= (r_armCount == ARM_MAX);
        end
    end

    // Register file, event latch and interrupt; hardware set beats a same-cycle W1C, reads see pre-write values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_event      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_capture    <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            r_event   <= r_armed ? w_event : '0;
            r_pending <= (r_pending & ~w_clearBits) | r_event;
            if (avs_write && (avs_address == ADDR_MASK)) begin
                r_mask <= avs_writedata[NUM_INPUTS-1:0];
            end
            if (|r_event) begin
                r_capture <= w_status;
            end
            irq <= |(r_pending & r_mask);
            if (avs_read) begin
                case (regAddr_t'(avs_address))
                    ADDR_STATUS:  avs_readdata <= zeroExtend(w_status);
                    ADDR_PENDING: avs_readdata <= zeroExtend(r_pending);
                    ADDR_MASK:    avs_readdata <= zeroExtend(r_mask);
                    default:      avs_readdata <= zeroExtend(r_capture);
                endcase
            end
        end
    end

endmodule
